// File: rtl/retire_queue_pkg.sv
// Shared sizing for the retire queue: default data width, depth, tag width and pointer width.
// Pointers carry one extra wrap bit above the tag so full and empty stay distinguishable.
package retire_queue_pkg;

  localparam int RQ_WIDTH = 32;
  localparam int RQ_SIZE  = 16;
  localparam int RQ_TAG_W = 4;
  localparam int RQ_PTR_W = RQ_TAG_W + 1;

  function automatic int ptr_width(input int tag_w);
    return tag_w + 1;
  endfunction

endpackage

// File: rtl/retire_queue_entry.sv
// One retire-queue slot: done flag plus result data; clear beats set in the same cycle.
// Single-cycle update on i_clk, no backpressure (always accepts set/clear).
module retire_queue_entry
  import retire_queue_pkg::*;
#(
  parameter int WIDTH = RQ_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_set,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_done,
  output logic [WIDTH-1:0] o_data
);

  logic             done_q;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      done_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (i_clr) begin
        done_q <= 1'b0;
      end else if (i_set) begin
        done_q <= 1'b1;
      end
      if (i_set) begin
        data_q <= i_d;
      end
    end
  end

  assign o_done = done_q;
  assign o_data = data_q;

endmodule

// File: rtl/retire_queue.sv
// In-order retire queue: alloc at tail, out-of-order completion by tag, valid/ready retire at head.
// Completion visible to retire one cycle later; alloc blocked by registered full; optional o_err via RETIRE_QUEUE_ERR_EN.
module retire_queue
  import retire_queue_pkg::*;
#(
  parameter int WIDTH = RQ_WIDTH,
  parameter int SIZE  = RQ_SIZE,
  parameter int TAG_W = RQ_TAG_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_alloc,
  output logic [TAG_W-1:0] o_alloc_tag,
  output logic             o_full,
  output logic             o_empty,
  output logic [TAG_W:0]   o_count,
  input  logic             i_cmp_valid,
  input  logic [TAG_W-1:0] i_cmp_tag,
  input  logic [WIDTH-1:0] i_cmp_data,
  output logic             o_ret_valid,
  output logic [TAG_W-1:0] o_ret_tag,
  output logic [WIDTH-1:0] o_ret_data,
  input  logic             i_ret_ready,
  input  logic             i_flush
`ifdef RETIRE_QUEUE_ERR_EN
  ,
  output logic             o_err
`endif
);

  localparam int PTR_W = ptr_width(TAG_W);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] count;
  logic [TAG_W-1:0] head_idx, tail_idx, cmp_off;
  logic             full, empty, in_range;
  logic             alloc_acc, cmp_acc, ret_fire;
  logic [SIZE-1:0]  done_w, set_w, clr_w;
  logic [WIDTH-1:0] data_w [SIZE];

  assign count    = tail_q - head_q;
  assign full     = (count == PTR_W'(SIZE));
  assign empty    = (count == '0);
  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];

  // Offset from head, modulo SIZE; the tag is live iff that offset is below count.
  // The slot being allocated right now sits at offset count, so it is never live.
  assign cmp_off  = i_cmp_tag - head_idx;
  assign in_range = ({1'b0, cmp_off} < count);

  assign alloc_acc = i_alloc & ~full & ~i_flush;
  assign cmp_acc   = i_cmp_valid & in_range & ~i_flush;
  assign ret_fire  = o_ret_valid & i_ret_ready & ~i_flush;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (i_flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (alloc_acc) tail_d = tail_q + PTR_W'(1);
      if (ret_fire)  head_d = head_q + PTR_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_comb begin
    set_w = '0;
    clr_w = '0;
    if (i_flush) begin
      clr_w = '1;
    end else begin
      if (alloc_acc) clr_w[tail_idx]  = 1'b1;
      if (ret_fire)  clr_w[head_idx]  = 1'b1;
      if (cmp_acc)   set_w[i_cmp_tag] = 1'b1;
    end
  end

  for (genvar g = 0; g < SIZE; g++) begin : g_entry
    retire_queue_entry #(
      .WIDTH(WIDTH)
    ) u_entry (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_set  (set_w[g]),
      .i_clr  (clr_w[g]),
      .i_d    (i_cmp_data),
      .o_done (done_w[g]),
      .o_data (data_w[g])
    );
  end

  assign o_alloc_tag = tail_idx;
  assign o_full      = full;
  assign o_empty     = empty;
  assign o_count     = count;
  assign o_ret_valid = ~empty & done_w[head_idx];
  assign o_ret_tag   = head_idx;
  assign o_ret_data  = data_w[head_idx];

`ifdef RETIRE_QUEUE_ERR_EN
  logic err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= 1'b0;
    end else if (i_flush) begin
      err_q <= 1'b0;
    end else if ((i_alloc & full) | (i_cmp_valid & ~in_range)) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`endif

endmodule

// File: tb/tb_retire_queue.sv
// Directed table-driven bench for retire_queue at SIZE=4, WIDTH=32, plus a mid-operation reset sequence.
module tb_retire_queue;

  localparam int WIDTH = 32;
  localparam int SIZE  = 4;
  localparam int TAG_W = 2;

  logic             clk;
  logic             rst_n;
  logic             alloc;
  logic [TAG_W-1:0] alloc_tag;
  logic             full, empty;
  logic [TAG_W:0]   count;
  logic             cmp_valid;
  logic [TAG_W-1:0] cmp_tag;
  logic [WIDTH-1:0] cmp_data;
  logic             ret_valid;
  logic [TAG_W-1:0] ret_tag;
  logic [WIDTH-1:0] ret_data;
  logic             ret_ready;
  logic             flush;
`ifdef RETIRE_QUEUE_ERR_EN
  logic             err;
`endif

  retire_queue #(
    .WIDTH(WIDTH),
    .SIZE (SIZE),
    .TAG_W(TAG_W)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_alloc    (alloc),
    .o_alloc_tag(alloc_tag),
    .o_full     (full),
    .o_empty    (empty),
    .o_count    (count),
    .i_cmp_valid(cmp_valid),
    .i_cmp_tag  (cmp_tag),
    .i_cmp_data (cmp_data),
    .o_ret_valid(ret_valid),
    .o_ret_tag  (ret_tag),
    .o_ret_data (ret_data),
    .i_ret_ready(ret_ready),
    .i_flush    (flush)
`ifdef RETIRE_QUEUE_ERR_EN
    ,
    .o_err      (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs applied for one cycle; expected outputs are the state seen before that cycle's edge.
  typedef struct {
    bit    a;
    bit    cv;
    int    ct;
    int    cd;
    bit    r;
    bit    f;
    int    tag;
    bit    full;
    bit    empty;
    int    cnt;
    bit    rv;
    int    rtag;
    bit    chkd;
    int    rdat;
    bit    err;
  } vec_t;

  vec_t tbl[$];
  int   n_chk;
  int   n_pass;

  function automatic vec_t mk(bit a, bit cv, int ct, int cd, bit r, bit f,
                              int tag, bit fl, bit em, int cnt, bit rv, int rtag,
                              bit chkd, int rdat, bit err_e);
    vec_t v;
    v.a = a; v.cv = cv; v.ct = ct; v.cd = cd; v.r = r; v.f = f;
    v.tag = tag; v.full = fl; v.empty = em; v.cnt = cnt; v.rv = rv;
    v.rtag = rtag; v.chkd = chkd; v.rdat = rdat; v.err = err_e;
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", nm, idx, act, exp);
  endtask

  task automatic idle_inputs();
    alloc = 1'b0; cmp_valid = 1'b0; cmp_tag = '0; cmp_data = '0;
    ret_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin
    vec_t t;
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    idle_inputs();

    //          a cv ct  cd     r f | tag fl em cnt rv rt chkd rdat  err
    // fill to 4, reject fifth alloc, flush
    tbl.push_back(mk(0,0,0,0,     0,0, 0,0,1,0,0,0,1,0,    0));
    tbl.push_back(mk(1,0,0,0,     0,0, 0,0,1,0,0,0,0,0,    0));
    tbl.push_back(mk(1,0,0,0,     0,0, 1,0,0,1,0,0,0,0,    0));
    tbl.push_back(mk(1,0,0,0,     0,0, 2,0,0,2,0,0,0,0,    0));
    tbl.push_back(mk(1,0,0,0,     0,0, 3,0,0,3,0,0,0,0,    0));
    tbl.push_back(mk(1,0,0,0,     0,0, 0,1,0,4,0,0,0,0,    0));
    tbl.push_back(mk(0,0,0,0,     0,0, 0,1,0,4,0,0,0,0,    1));
    tbl.push_back(mk(0,0,0,0,     0,1, 0,1,0,4,0,0,0,0,    1));
    tbl.push_back(mk(0,0,0,0,     0,0, 0,0,1,0,0,0,0,0,    0));
    // out-of-order completion, in-order retire, no same-cycle bypass
    tbl.push_back(mk(1,0,0,0,     0,0, 0,0,1,0,0,0,0,0,    0));
    tbl.push_back(mk(1,0,0,0,     0,0, 1,0,0,1,0,0,0,0,    0));
    tbl.push_back(mk(1,0,0,0,     0,0, 2,0,0,2,0,0,0,0,    0));
    tbl.push_back(mk(0,1,2,'hBB,  0,0, 3,0,0,3,0,0,0,0,    0));
    tbl.push_back(mk(0,1,1,'hAA,  0,0, 3,0,0,3,0,0,0,0,    0));
    tbl.push_back(mk(0,1,0,'h11,  1,0, 3,0,0,3,0,0,0,0,    0));
    tbl.push_back(mk(0,0,0,0,     1,0, 3,0,0,3,1,0,1,'h11, 0));
    tbl.push_back(mk(0,0,0,0,     1,0, 3,0,0,2,1,1,1,'hAA, 0));
    tbl.push_back(mk(0,0,0,0,     1,0, 3,0,0,1,1,2,1,'hBB, 0));
    tbl.push_back(mk(0,0,0,0,     0,0, 3,0,1,0,0,3,0,0,    0));
    // full queue: alloc+retire together, alloc rejected, then accepted
    tbl.push_back(mk(0,0,0,0,     0,1, 3,0,1,0,0,3,0,0,    0));
    tbl.push_back(mk(1,0,0,0,     0,0, 0,0,1,0,0,0,0,0,    0));
    tbl.push_back(mk(1,0,0,0,     0,0, 1,0,0,1,0,0,0,0,    0));
    tbl.push_back(mk(1,0,0,0,     0,0, 2,0,0,2,0,0,0,0,    0));
    tbl.push_back(mk(1,0,0,0,     0,0, 3,0,0,3,0,0,0,0,    0));
    tbl.push_back(mk(0,1,0,'h33,  0,0, 0,1,0,4,0,0,0,0,    0));
    tbl.push_back(mk(1,0,0,0,     1,0, 0,1,0,4,1,0,1,'h33, 0));
    tbl.push_back(mk(1,0,0,0,     0,0, 0,0,0,3,0,1,0,0,    1));
    tbl.push_back(mk(0,0,0,0,     0,0, 1,1,0,4,0,1,0,0,    1));
    tbl.push_back(mk(0,0,0,0,     0,1, 1,1,0,4,0,1,0,0,    1));
    // streaming across the pointer wrap: alloc k, complete k-1, retire k-2
    tbl.push_back(mk(1,0,0,0,     1,0, 0,0,1,0,0,0,0,0,    0));
    tbl.push_back(mk(1,1,0,'h100, 1,0, 1,0,0,1,0,0,0,0,    0));
    for (int k = 2; k < 10; k++)
      tbl.push_back(mk(1,1,(k-1)%4,'h100+k-1, 1,0, k%4,0,0,2,1,(k-2)%4,1,'h100+k-2, 0));
    tbl.push_back(mk(0,1,1,'h109, 1,0, 2,0,0,2,1,0,1,'h108, 0));
    tbl.push_back(mk(0,0,0,0,     1,0, 2,0,0,1,1,1,1,'h109, 0));
    tbl.push_back(mk(0,0,0,0,     0,0, 2,0,1,0,0,2,0,0,    0));
    // completion to the tag being allocated is ignored; flush beats alloc/complete/retire
    tbl.push_back(mk(1,1,2,'h77,  0,0, 2,0,1,0,0,2,0,0,    0));
    tbl.push_back(mk(1,0,0,0,     0,0, 3,0,0,1,0,2,0,0,    1));
    tbl.push_back(mk(1,1,2,'h55,  0,0, 0,0,0,2,0,2,0,0,    1));
    tbl.push_back(mk(1,1,3,'h66,  1,1, 1,0,0,3,1,2,1,'h55, 1));
    tbl.push_back(mk(0,0,0,0,     0,0, 0,0,1,0,0,0,0,0,    0));
    tbl.push_back(mk(0,0,0,0,     0,0, 0,0,1,0,0,0,0,0,    0));

    #2;
    check("reset_empty", -1, 32'(empty), 32'd1);
    check("reset_ret_valid", -1, 32'(ret_valid), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      if (i != 0) @(negedge clk);
      alloc     = t.a;
      cmp_valid = t.cv;
      cmp_tag   = TAG_W'(t.ct);
      cmp_data  = WIDTH'(t.cd);
      ret_ready = t.r;
      flush     = t.f;
      #1;
      check("alloc_tag", i, 32'(alloc_tag), 32'(t.tag));
      check("full",      i, 32'(full),      32'(t.full));
      check("empty",     i, 32'(empty),     32'(t.empty));
      check("count",     i, 32'(count),     32'(t.cnt));
      check("ret_valid", i, 32'(ret_valid), 32'(t.rv));
      check("ret_tag",   i, 32'(ret_tag),   32'(t.rtag));
      if (t.chkd) check("ret_data", i, ret_data, 32'(t.rdat));
`ifdef RETIRE_QUEUE_ERR_EN
      check("err", i, 32'(err), 32'(t.err));
`endif
    end

    // mid-operation asynchronous reset: two allocs, complete head, then pull reset mid-cycle
    @(negedge clk); idle_inputs(); alloc = 1'b1;
    @(negedge clk); alloc = 1'b1;
    @(negedge clk); alloc = 1'b0; cmp_valid = 1'b1; cmp_tag = 2'd0; cmp_data = 32'h99;
    @(negedge clk); idle_inputs();
    #1;
    check("pre_rst_ret_valid", 100, 32'(ret_valid), 32'd1);
    check("pre_rst_ret_data",  100, ret_data,       32'h99);
    check("pre_rst_count",     100, 32'(count),     32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_empty",     101, 32'(empty),     32'd1);
    check("rst_full",      101, 32'(full),      32'd0);
    check("rst_count",     101, 32'(count),     32'd0);
    check("rst_ret_valid", 101, 32'(ret_valid), 32'd0);
    check("rst_alloc_tag", 101, 32'(alloc_tag), 32'd0);
    check("rst_ret_data",  101, ret_data,       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_empty", 102, 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/retire_queue.md
Name: retire_queue

Overview:
- In-order drain end of the ring-buffer protocol.
- Entries are allocated in order at the tail and return a tag.
- Entries are completed out of order by tag, carrying data.
- Entries are read and retired strictly in order from the head, using a valid/ready handshake.
- Sits between rename/dispatch (alloc), execution units (completion) and the commit stage (retire).

Parameters:
- WIDTH, 32, completion/retire data width.
- SIZE, 16, number of entries; power of two, at least 2.
- TAG_W, 4, tag width; must equal log2(SIZE).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous reset, active low.
- i_alloc  input  1  allocation request.
- o_alloc_tag  output  TAG_W  tag granted this cycle (the tail index).
- o_full  output  1  queue holds SIZE entries.
- o_empty  output  1  queue holds 0 entries.
- o_count  output  TAG_W+1  number of occupied entries.
- i_cmp_valid  input  1  completion strobe.
- i_cmp_tag  input  TAG_W  tag being completed.
- i_cmp_data  input  WIDTH  result data for that tag.
- o_ret_valid  output  1  head entry is done and may be retired.
- o_ret_tag  output  TAG_W  head index.
- o_ret_data  output  WIDTH  head entry data.
- i_ret_ready  input  1  commit stage accepts the head entry.
- i_flush  input  1  synchronous flush of all entries.

Behaviour:
- Reset (async, i_rst_n=0):
  - head = tail = 0, count = 0; all done bits and data cleared.
  - o_empty=1, o_full=0, o_ret_valid=0, o_alloc_tag=0, o_ret_data=0.
- State:
  - head and tail are TAG_W+1-bit pointers; the MSB is the wrap bit.
  - count = tail - head, modulo 2^(TAG_W+1).
  - full = (count==SIZE); empty = (count==0).
- Alloc:
  - Accepted when i_alloc & ~o_full.
  - o_alloc_tag is the current tail[TAG_W-1:0], combinational and valid in the same cycle.
  - On accept: tail increments and done[tag] is cleared.
  - An alloc request while full is ignored; no state change.
- Completion:
  - When i_cmp_valid is set and the tag lies inside [head,tail) as registered at the start of the cycle: done[tag] <= 1, data[tag] <= i_cmp_data.
  - A tag outside that range is ignored.
  - A completion to the tag allocated in the same cycle is ignored.
  - Completing an already-done entry overwrites its data.
- Retire:
  - o_ret_valid = ~empty & done[head].
  - o_ret_data and o_ret_tag come from the head entry.
  - Retire fires on o_ret_valid & i_ret_ready: head increments and done[head] clears.
- Latency:
  - A completion at edge N is retirable in cycle N+1 at the earliest; there is no same-cycle bypass.
  - Throughput is 1 alloc, 1 completion and 1 retire per cycle, concurrently.
- Simultaneous events:
  - Alloc and retire together: count is unchanged.
  - When full, a same-cycle retire does not enable alloc, because o_full is taken from the registered count.
- Wrap-around: pointers roll from 2*SIZE-1 to 0; indices wrap modulo SIZE; full and empty are distinguished by the wrap bit.
- Flush:
  - Synchronous. head = tail = 0, count = 0, all done bits cleared.
  - Has priority over alloc, completion and retire in the same cycle; none of them take effect.
  - o_ret_valid is 0 in the following cycle.
- Reset asserted mid-operation returns every output to its reset value immediately.

Optional Feature:
- Macro: RETIRE_QUEUE_ERR_EN.
- Defined:
  - Adds output o_err (1 bit), sticky, cleared only by reset or flush.
  - Set on alloc while full.
  - Set on a completion whose tag is not allocated.
  - Set on a retire handshake while o_ret_valid=0 is NOT an error.
- Undefined: no o_err port; the same illegal events are silently ignored.

Decomposition:
- Shared header/package: default WIDTH/SIZE/TAG_W and the pointer-width localparam (TAG_W+1).
- Natural sub-module: retire_queue_entry.
  - One slot: done bit plus WIDTH data register.
  - Inputs: set (completion), clear (alloc / retire / flush), i_d, i_clk, i_rst_n.
  - Instanced SIZE times in a generate loop.
  - Read mux over entries is selected by head.

Test Plan (SIZE=4, WIDTH=32):
- Reset, then 4 allocs -> tags 0,1,2,3; o_full=1 and o_count=4. Fifth alloc -> tail unchanged (with ERR_EN: o_err=1).
- Alloc 3; complete tags 2,1 with 0xBB, 0xAA -> o_ret_valid stays 0. Complete tag 0 with 0x11 -> next cycle retires, with ready held, give 0x11, 0xAA, 0xBB in three consecutive cycles.
- Complete at edge N with i_ret_ready=1 -> o_ret_valid=0 in cycle N, 1 in cycle N+1.
- Full queue, head done, alloc+retire same cycle -> retire occurs, alloc rejected, o_count=3. Next cycle alloc succeeds, o_alloc_tag=0.
- Run 10 alloc/complete/retire cycles -> tags cycle 0..3 repeatedly, empty/full correct across the pointer wrap, data intact.
- Flush with 3 entries (1 done) while alloc+complete+retire are also asserted -> next cycle o_empty=1, o_ret_valid=0, o_alloc_tag=0; no retire observed.
